backprop_sequencer: RTL

BACKPROP_SEQUENCER -- requirements
Module: backprop_sequencer

---
 rtl/backprop_sequencer.sv | 111 +++++++++++
 1 files changed

// File: rtl/backprop_sequencer.sv
// Backprop sweep sequencer: clears the stack, then walks layers N-1..0 through COPY/CAL/READ.
// Optional READ stall handshake (dc_dw_ready) enabled by defining BACKPROP_SEQ_STALL_EN.
module backprop_sequencer #(
  parameter int data_size      = 8,
  parameter int size           = 3,
  parameter int max_layer_size = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [32:0]               num_layers,
`ifdef BACKPROP_SEQ_STALL_EN
  input  logic                      dc_dw_ready,
`endif
  output logic                      stack_reset,
  output logic [32:0]               current_layer_index,
  output logic [32:0]               dc_dw_layer_index,
  output logic                      copy,
  output logic                      cal_dy_dy_old,
  input  logic [data_size*size-1:0] dc_dw_stream,
  output logic [data_size*size-1:0] dc_dw_out,
  output logic                      dc_dw_valid,
  output logic                      busy,
  output logic                      done
);

  localparam logic [32:0] LAYER_LIMIT = 33'(max_layer_size);

  typedef enum logic [2:0] {IDLE, CLEAR, COPY, CAL, READ, DONE} state_t;

  state_t      state, next_state;
  logic [32:0] count;
  logic [32:0] layer;
  logic [32:0] dw_idx;
  logic        ready;
  logic        capture;

`ifdef BACKPROP_SEQ_STALL_EN
  assign ready = dc_dw_ready;
`else
  assign ready = 1'b1;
`endif

  assign current_layer_index = layer;
  assign dc_dw_layer_index   = dw_idx;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state    = state;
    stack_reset   = 1'b0;
    copy          = 1'b0;
    cal_dy_dy_old = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    capture       = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) next_state = CLEAR;
      end
      CLEAR: begin
        stack_reset = 1'b1;
        next_state  = (count != '0) ? COPY : DONE;
      end
      COPY: begin
        copy       = 1'b1;
        next_state = CAL;
      end
      CAL: begin
        cal_dy_dy_old = 1'b1;
        next_state    = READ;
      end
      READ: begin
        if (ready) begin
          capture    = 1'b1;
          next_state = (layer != '0) ? COPY : DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // layer doubles as current_layer_index: loaded on CLEAR->COPY, decremented
  // only on READ->COPY so it holds its last value through DONE and IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      layer       <= '0;
      dw_idx      <= '0;
      dc_dw_out   <= '0;
      dc_dw_valid <= 1'b0;
    end else begin
      dc_dw_valid <= capture;
      if (capture) dc_dw_out <= dc_dw_stream;
      if (state == IDLE && start)
        count <= (num_layers > LAYER_LIMIT) ? LAYER_LIMIT : num_layers;
      if (state == CLEAR && count != '0) layer <= count - 33'd1;
      if (capture && layer != '0) layer <= layer - 33'd1;
      if (state == CAL) dw_idx <= layer;
    end
  end

endmodule
